// File: rtl/shift_frame_piso_if.sv
// shift_frame_piso_if: load handshake, shift strobe and serial/parallel result bundle.
interface shift_frame_piso_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             en;
    logic             sin;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] par_out;
    modport master (
        output clear, load_valid, load_data, en, sin,
        input  load_ready, sout, sout_valid, busy, done, par_out
    );
    modport slave (
        input  clear, load_valid, load_data, en, sin,
        output load_ready, sout, sout_valid, busy, done, par_out
    );
endinterface

// File: rtl/shift_frame_piso.sv
// shift_frame_piso: framed PISO/SIPO shift register with valid/ready load and gap-free reload.
module shift_frame_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    shift_frame_piso_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_done;
    logic [WIDTH-1:0] r_par_out;
    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shifted;
    assign w_shift   = (r_state == SHIFT) & bus.en;
    assign w_last    = w_shift & (r_cnt == CW'(1));
    assign w_ready   = (r_state == IDLE) | w_last;
    assign w_accept  = bus.load_valid & w_ready & ~bus.clear;
    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], bus.sin} : {bus.sin, r_shreg[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    // A same-cycle accept on the last bit keeps us in SHIFT for gap-free streaming.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear)     w_state_nxt = IDLE;
        else if (w_accept) w_state_nxt = SHIFT;
        else if (w_last)   w_state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_par_out    <= '0;
        end else if (bus.clear) begin
            r_cnt        <= '0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sout_valid <= w_shift;
            r_done       <= w_last;
            if (w_shift) r_sout <= w_out_bit;
            if (w_last)  r_par_out <= w_shifted;
            r_shreg <= w_accept ? bus.load_data : (w_shift ? w_shifted : r_shreg);
            r_cnt   <= w_accept ? CW'(WIDTH) : (w_shift ? r_cnt - CW'(1) : r_cnt);
        end
    end
    assign bus.load_ready = w_ready;
    assign bus.busy       = (r_state == SHIFT);
    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.done       = r_done;
    assign bus.par_out    = r_par_out;
endmodule
